// File: rtl/pc_fetch_ctrl.sv
// PC register and single-outstanding instruction fetch sequencer for the CPU front end.
// Optional trap redirect (trap in, epc out) is compiled in when PC_TRAP_EN is defined.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
`ifdef PC_TRAP_EN
    ,
    parameter logic [31:0] TRAP_VEC = 32'h0000_4180
`endif
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic [1:0]  npcctr,
    input  logic [15:0] br_offset,
    input  logic [25:0] j_addr,
    output logic [31:0] inst_count
`ifdef PC_TRAP_EN
    ,
    input  logic        trap,
    output logic [31:0] epc
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] count_q, count_d;
    logic [31:0] npc;
`ifdef PC_TRAP_EN
    logic [31:0] epc_q, epc_d;
    logic        trap_pend_q, trap_pend_d;
`endif

    // Next PC is always relative to the held instruction's own PC.
    always_comb begin
        npc = inst_pc_q + 32'd4;
        case (npcctr)
            2'b01:   npc = inst_pc_q + 32'd4 + {{14{br_offset[15]}}, br_offset, 2'b00};
            2'b10:   npc = {inst_pc_q[31:28], j_addr, 2'b00};
            default: npc = inst_pc_q + 32'd4;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        count_d   = count_q;
`ifdef PC_TRAP_EN
        epc_d       = epc_q;
        trap_pend_d = trap_pend_q;
`endif
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
`ifdef PC_TRAP_EN
                // A trap seen during the fetch lets the bus transaction finish, then drops the word.
                if (imem_ack) begin
                    if (trap_pend_q || trap) begin
                        epc_d       = pc_q;
                        pc_d        = TRAP_VEC;
                        trap_pend_d = 1'b0;
                    end else begin
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        state_d   = HOLD;
                    end
                end else if (trap) begin
                    trap_pend_d = 1'b1;
                end
`else
                if (imem_ack) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    state_d   = HOLD;
                end
`endif
            end
            HOLD: begin
`ifdef PC_TRAP_EN
                if (trap) begin
                    epc_d   = inst_pc_q;
                    pc_d    = TRAP_VEC;
                    state_d = REQ;
                end else if (inst_ready) begin
                    pc_d    = npc;
                    count_d = count_q + 32'd1;
                    state_d = REQ;
                end
`else
                if (inst_ready) begin
                    pc_d    = npc;
                    count_d = count_q + 32'd1;
                    state_d = REQ;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            inst_q    <= 32'd0;
            inst_pc_q <= RESET_PC;
            count_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            count_q   <= count_d;
        end
    end

`ifdef PC_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_q       <= 32'd0;
            trap_pend_q <= 1'b0;
        end else begin
            epc_q       <= epc_d;
            trap_pend_q <= trap_pend_d;
        end
    end

    assign epc = epc_q;
`endif

    assign imem_req   = (state_q == REQ);
    assign inst_valid = (state_q == HOLD);
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_count = count_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: the bench plays instruction memory and decode.
// Trap scenarios are included when PC_TRAP_EN is defined.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [1:0]  npcctr;
    logic [15:0] br_offset;
    logic [25:0] j_addr;
    logic [31:0] inst_count;
`ifdef PC_TRAP_EN
    logic        trap;
    logic [31:0] epc;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_inst_q[$];
    logic [31:0] m_count;
    logic [31:0] m_inst_pc;

    pc_fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .npcctr     (npcctr),
        .br_offset  (br_offset),
        .j_addr     (j_addr),
        .inst_count (inst_count)
`ifdef PC_TRAP_EN
        ,
        .trap       (trap),
        .epc        (epc)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [1:0] sel,
                                              input logic [15:0] off, input logic [25:0] ja);
        case (sel)
            2'b01:   return pc + 32'd4 + {{14{off[15]}}, off, 2'b00};
            2'b10:   return {pc[31:28], ja, 2'b00};
            default: return pc + 32'd4;
        endcase
    endfunction

    task automatic apply_reset();
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        inst_ready = 1'b0;
        npcctr     = 2'b00;
        br_offset  = 16'd0;
        j_addr     = 26'd0;
`ifdef PC_TRAP_EN
        trap = 1'b0;
`endif
        exp_addr_q.delete();
        exp_inst_q.delete();
        m_count   = 32'd0;
        m_inst_pc = RESET_PC;
        exp_addr_q.push_back(RESET_PC);
        step();
        step();
        rst = 1'b0;
    endtask

    // Memory side: wait for the request, stall ack_wait cycles, then return rdata.
    task automatic do_fetch(input int ack_wait, input logic [31:0] rdata, output int waited);
        logic [31:0] exp_a;
        logic [63:0] exp_i;
        waited = 0;
        while (imem_req !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fetch_timeout: imem_req=%b required 1", imem_req);
            return;
        end
        exp_a = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if (imem_addr !== exp_a) begin
            errors++;
            $display("[TB] FAIL fetch_addr: imem_addr=%h required %h", imem_addr, exp_a);
        end
        for (int i = 0; i < ack_wait; i++) begin
            step();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_a || inst_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL req_hold: req=%b addr=%h valid=%b required 1 %h 0",
                         imem_req, imem_addr, inst_valid, exp_a);
            end
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        exp_inst_q.push_back({rdata, exp_a});
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        exp_i = exp_inst_q.pop_front();
        checks++;
        if (inst_valid !== 1'b1 || inst !== exp_i[63:32] || inst_pc !== exp_i[31:0] || imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fetch_data: valid=%b req=%b inst=%h pc=%h required 1 0 %h %h",
                     inst_valid, imem_req, inst, inst_pc, exp_i[63:32], exp_i[31:0]);
        end
        m_inst_pc = exp_i[31:0];
    endtask

    // Decode side: refuse for ready_wait cycles with noise on ignored inputs, then accept.
    task automatic do_accept(input int ready_wait, input logic [1:0] sel,
                             input logic [15:0] off, input logic [25:0] ja);
        logic [31:0] hold_inst;
        logic [31:0] hold_pc;
        hold_inst = inst;
        hold_pc   = inst_pc;
        for (int i = 0; i < ready_wait; i++) begin
            npcctr    = 2'($urandom);
            br_offset = 16'($urandom);
            j_addr    = 26'($urandom);
            imem_ack  = 1'($urandom);
            step();
            checks++;
            if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst !== hold_inst || inst_pc !== hold_pc) begin
                errors++;
                $display("[TB] FAIL hold_stable: valid=%b req=%b inst=%h pc=%h required 1 0 %h %h",
                         inst_valid, imem_req, inst, inst_pc, hold_inst, hold_pc);
            end
        end
        imem_ack   = 1'b0;
        inst_ready = 1'b1;
        npcctr     = sel;
        br_offset  = off;
        j_addr     = ja;
        exp_addr_q.push_back(model_npc(m_inst_pc, sel, off, ja));
        m_count++;
        step();
        inst_ready = 1'b0;
        npcctr     = 2'($urandom);
        br_offset  = 16'($urandom);
        j_addr     = 26'($urandom);
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || inst_count !== m_count) begin
            errors++;
            $display("[TB] FAIL accept: valid=%b req=%b count=%0d required 0 1 %0d",
                     inst_valid, imem_req, inst_count, m_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_ack = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b0;
        npcctr = 2'b00; br_offset = 16'd0; j_addr = 26'd0;
`ifdef PC_TRAP_EN
        trap = 1'b0;
`endif
        step();
        step();
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: %b required 0", imem_req); end
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: %b required 0", inst_valid); end
        checks++;
        if (inst_pc !== RESET_PC) begin errors++; $display("[TB] FAIL reset_inst_pc: %h required %h", inst_pc, RESET_PC); end
        checks++;
        if (inst_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_count: %0d required 0", inst_count); end
        checks++;
        if (imem_addr !== RESET_PC || inst !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_addr_inst: addr=%h inst=%h required %h 0", imem_addr, inst, RESET_PC);
        end
`ifdef PC_TRAP_EN
        checks++;
        if (epc !== 32'd0) begin errors++; $display("[TB] FAIL reset_epc: %h required 0", epc); end
`endif
    endtask

    task automatic test_sequential();
        int w;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            do_fetch(0, 32'hA000_0000 + 32'(k), w);
            if (k > 0) begin
                checks++;
                if (w !== 0) begin errors++; $display("[TB] FAIL loop_latency: waited %0d required 0", w); end
            end
            do_accept(0, 2'b00, 16'd0, 26'd0);
        end
        checks++;
        if (inst_count !== 32'd3 || imem_addr !== 32'h0000_300C) begin
            errors++;
            $display("[TB] FAIL seq_count: count=%0d addr=%h required 3 0000300c", inst_count, imem_addr);
        end
    endtask

    task automatic test_reset_mid_req();
        int w;
        apply_reset();
        do_fetch(0, 32'h1234_5678, w);
        do_accept(0, 2'b00, 16'd0, 26'd0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3004) begin
            errors++;
            $display("[TB] FAIL pre_reset_req: req=%b addr=%h required 1 00003004", imem_req, imem_addr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst_pc !== RESET_PC ||
            inst_count !== 32'd0 || imem_addr !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL async_reset: req=%b valid=%b pc=%h count=%0d addr=%h required 0 0 %h 0 %h",
                     imem_req, inst_valid, inst_pc, inst_count, imem_addr, RESET_PC, RESET_PC);
        end
        exp_addr_q.delete();
        exp_inst_q.delete();
        m_count = 32'd0;
        exp_addr_q.push_back(RESET_PC);
        step();
        rst = 1'b0;
        do_fetch(0, 32'h0BAD_F00D, w);
        do_accept(0, 2'b00, 16'd0, 26'd0);
    endtask

    task automatic test_branch_jump();
        int w;
        apply_reset();
        do_fetch(0, 32'h1, w); do_accept(0, 2'b11, 16'h1234, 26'h3FF_FFFF);
        do_fetch(0, 32'h2, w); do_accept(0, 2'b00, 16'd0, 26'd0);
        do_fetch(0, 32'h3, w);
        checks++;
        if (inst_pc !== 32'h0000_3008) begin errors++; $display("[TB] FAIL branch_src: %h required 00003008", inst_pc); end
        do_accept(0, 2'b01, 16'hFFFF, 26'd0);
        checks++;
        if (imem_addr !== 32'h0000_3008) begin errors++; $display("[TB] FAIL branch_target: %h required 00003008", imem_addr); end
        do_fetch(0, 32'h4, w); do_accept(0, 2'b01, 16'h0001, 26'd0);
        checks++;
        if (imem_addr !== 32'h0000_3010) begin errors++; $display("[TB] FAIL branch_fwd: %h required 00003010", imem_addr); end
        do_fetch(0, 32'h5, w); do_accept(0, 2'b10, 16'd0, 26'h000_0C00);
        checks++;
        if (imem_addr !== 32'h0000_3000) begin errors++; $display("[TB] FAIL jump_target: %h required 00003000", imem_addr); end
        do_fetch(0, 32'h6, w); do_accept(0, 2'b00, 16'd0, 26'd0);
    endtask

    task automatic test_backpressure();
        int w;
        apply_reset();
        do_fetch(3, 32'hCAFE_0001, w);
        do_accept(5, 2'b00, 16'd0, 26'd0);
        do_fetch(3, 32'hCAFE_0002, w);
        do_accept(5, 2'b01, 16'hFFFE, 26'd0);
        checks++;
        if (imem_addr !== 32'h0000_3000 || inst_count !== 32'd2) begin
            errors++;
            $display("[TB] FAIL backpressure_end: addr=%h count=%0d required 00003000 2", imem_addr, inst_count);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            do_fetch($urandom_range(0, 3), $urandom, w);
            do_accept($urandom_range(0, 3), 2'($urandom), 16'($urandom), 26'($urandom));
        end
        do_fetch(0, 32'h0, w);
        checks++;
        if (inst_count !== 32'd12) begin errors++; $display("[TB] FAIL b2b_count: %0d required 12", inst_count); end
    endtask

`ifdef PC_TRAP_EN
    task automatic test_trap();
        int w;
        apply_reset();
        do_fetch(0, 32'h1111_0000, w); do_accept(0, 2'b00, 16'd0, 26'd0);
        do_fetch(0, 32'h1111_0004, w);
        trap = 1'b1; inst_ready = 1'b1;
        step();
        trap = 1'b0; inst_ready = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_4180 ||
            epc !== 32'h0000_3004 || inst_count !== 32'd1) begin
            errors++;
            $display("[TB] FAIL trap_hold: valid=%b req=%b addr=%h epc=%h count=%0d required 0 1 00004180 00003004 1",
                     inst_valid, imem_req, imem_addr, epc, inst_count);
        end
        exp_addr_q.push_back(32'h0000_4180);
        do_fetch(0, 32'h2222_0000, w);
        do_accept(0, 2'b10, 16'd0, 26'h000_0C02);
        checks++;
        if (imem_addr !== 32'h0000_3008) begin errors++; $display("[TB] FAIL trap_ret: %h required 00003008", imem_addr); end
        void'(exp_addr_q.pop_front());
        trap = 1'b1;
        step();
        trap = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3008 || epc !== 32'h0000_3004) begin
                errors++;
                $display("[TB] FAIL trap_req_hold: req=%b addr=%h epc=%h required 1 00003008 00003004",
                         imem_req, imem_addr, epc);
            end
            step();
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_4180 || epc !== 32'h0000_3008) begin
            errors++;
            $display("[TB] FAIL trap_req: valid=%b req=%b addr=%h epc=%h required 0 1 00004180 00003008",
                     inst_valid, imem_req, imem_addr, epc);
        end
        exp_addr_q.push_back(32'h0000_4180);
        do_fetch(1, 32'h3333_0000, w);
        do_accept(0, 2'b00, 16'd0, 26'd0);
    endtask
`endif

    initial begin
        $display("[TB] starting pc_fetch_ctrl bench");
        test_reset();
        test_sequential();
        test_reset_mid_req();
        test_branch_jump();
        test_backpressure();
        test_back_to_back();
`ifdef PC_TRAP_EN
        test_trap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
